// File: rtl/instruction_fetch_pkg.sv
// Shared types and default constants for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int               ADDR_WIDTH_DEF  = 8;
  localparam int               DATA_WIDTH_DEF  = 8;
  localparam logic [7:0]       RESET_PC_DEF    = 8'h00;
  localparam logic [7:0]       HALT_OPCODE_DEF = 8'hFF;
  localparam int               COUNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory-side and decode-side signals of the fetch stage.
// fetch_count exists only when INSTRUCTION_FETCH_COUNT_EN is defined.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = instruction_fetch_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = instruction_fetch_pkg::DATA_WIDTH_DEF
) ();

  logic                  enable;
  logic [ADDR_WIDTH-1:0] instruction_address;
  logic [DATA_WIDTH-1:0] instruction_data;
  logic [DATA_WIDTH-1:0] ir_data;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  halted;
`ifdef INSTRUCTION_FETCH_COUNT_EN
  logic [15:0]           fetch_count;
`endif

  // Fetch stage side.
  modport master (
    input  enable, instruction_data, ir_ready, branch_taken, branch_target,
`ifdef INSTRUCTION_FETCH_COUNT_EN
    output fetch_count,
`endif
    output instruction_address, ir_data, ir_pc, ir_valid, halted
  );

  // Environment side: instruction memory, decode and control.
  modport slave (
    output enable, instruction_data, ir_ready, branch_taken, branch_target,
`ifdef INSTRUCTION_FETCH_COUNT_EN
    input  fetch_count,
`endif
    input  instruction_address, ir_data, ir_pc, ir_valid, halted
  );

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register. Next-PC priority lives here only:
// reset > branch redirect > advance (wraps modulo 2^ADDR_WIDTH) > hold.
module fetch_pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_branch,
  input  logic [ADDR_WIDTH-1:0] i_target,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // PC update: redirect wins over sequential advance; otherwise hold.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_branch) begin
      r_pc <= i_target;
    end else if (i_advance) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC drives instruction_mem combinationally, the returned byte
// is captured into a one-entry IR with a valid/ready handshake to decode.
// Optional build macro: INSTRUCTION_FETCH_COUNT_EN adds a saturating
// 16-bit capture counter on bus.fetch_count.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEF),
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = DATA_WIDTH'(HALT_OPCODE_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [ADDR_WIDTH-1:0] w_pc;
  logic [DATA_WIDTH-1:0] r_ir_data;
  logic [ADDR_WIDTH-1:0] r_ir_pc;
  logic                  r_ir_valid;
  logic                  r_halted;
  logic                  w_branch;
  logic                  w_capture;
  logic                  w_halt_fetch;
  logic                  w_accept;

  // Branches are ignored once halted; capture needs a free or draining IR.
  assign w_branch     = bus.branch_taken && (r_state != ST_HALT);
  assign w_capture    = (r_state == ST_RUN) && bus.enable && !bus.branch_taken
                        && (!r_ir_valid || bus.ir_ready);
  assign w_halt_fetch = w_capture && (bus.instruction_data == HALT_OPCODE);
  assign w_accept     = r_ir_valid && bus.ir_ready;

  // The PC stays on the halt address, so a halt capture does not advance.
  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .i_branch  (w_branch),
    .i_target  (bus.branch_target),
    .i_advance (w_capture && !w_halt_fetch),
    .o_pc      (w_pc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: HALT is terminal until reset.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.enable) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_halt_fetch)     w_state_next = ST_HALT;
        else if (!bus.enable) w_state_next = ST_IDLE;
      end
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // IR: flush on branch, load on capture, drain on accept; accepting the
  // halt instruction raises halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir_data  <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else if (w_branch) begin
      r_ir_valid <= 1'b0;
    end else if (w_capture) begin
      r_ir_data  <= bus.instruction_data;
      r_ir_pc    <= w_pc;
      r_ir_valid <= 1'b1;
    end else if (w_accept) begin
      r_ir_valid <= 1'b0;
      if (r_state == ST_HALT) r_halted <= 1'b1;
    end
  end

  assign bus.instruction_address = w_pc;
  assign bus.ir_data             = r_ir_data;
  assign bus.ir_pc               = r_ir_pc;
  assign bus.ir_valid            = r_ir_valid;
  assign bus.halted              = r_halted;

`ifdef INSTRUCTION_FETCH_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_fetch_count;

  // Capture counter, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_capture && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed sequences push the
// expected (data, pc) of every instruction decode should accept; a negedge
// monitor pops one entry per accepted handshake. Point checks cover reset,
// stall, flush, wrap, halt and asynchronous reset.
module tb_instruction_fetch;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] mem [256];
  exp_t       exp_q [$];
  int         n_total = 0;
  int         n_bad   = 0;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Asynchronous-read instruction memory.
  assign bus.instruction_data = mem[bus.instruction_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] data, input logic [7:0] pc);
    exp_t e;
    e.data = data;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.enable         = 1'b0;
    bus.ir_ready       = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every accepted IR must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.ir_valid && bus.ir_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL accept_unexpected: got data=%0h pc=%0h, required no transfer",
                 bus.ir_data, bus.ir_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("accept_data", 32'(bus.ir_data), 32'(e.data));
        check("accept_pc",   32'(bus.ir_pc),   32'(e.pc));
      end
    end
  end

  // Watchdog: the sequence below is short; this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hA1;
    mem[1] = 8'hA2;
    mem[2] = 8'hA3;
    mem[3] = 8'hA4;
    mem[8'h40] = 8'hB0;
    mem[8'hFE] = 8'hC0;
    mem[8'hFF] = 8'hC1;

    // Reset state.
    do_reset();
    check("rst_ir_valid", 32'(bus.ir_valid), 0);
    check("rst_ir_data",  32'(bus.ir_data), 0);
    check("rst_ir_pc",    32'(bus.ir_pc), 0);
    check("rst_halted",   32'(bus.halted), 0);
    check("rst_addr",     32'(bus.instruction_address), 0);
`ifdef INSTRUCTION_FETCH_COUNT_EN
    check("rst_count",    32'(bus.fetch_count), 0);
`endif

    // Streaming: one instruction per cycle, first valid one cycle after RUN.
    push(8'hA1, 8'h00);
    push(8'hA2, 8'h01);
    push(8'hA3, 8'h02);
    push(8'hA4, 8'h03);
    bus.enable   = 1'b1;
    bus.ir_ready = 1'b1;
    tick();
    check("stream_first_not_yet", 32'(bus.ir_valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_valid", 32'(bus.ir_valid), 1);
      check("stream_pc",    32'(bus.ir_pc), 32'(k));
      check("stream_addr",  32'(bus.instruction_address), 32'(k + 1));
    end
    bus.enable = 1'b0;
    tick();
    tick();
    check("stream_drained", 32'(bus.ir_valid), 0);
`ifdef INSTRUCTION_FETCH_COUNT_EN
    check("stream_count", 32'(bus.fetch_count), 4);
`endif

    // Stall with (A2,1) in the IR and PC=2.
    do_reset();
    push(8'hA1, 8'h00);
    push(8'hA2, 8'h01);
    push(8'hA3, 8'h02);
    bus.enable   = 1'b1;
    bus.ir_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_data",  32'(bus.ir_data), 32'h A2);
      check("stall_pc",    32'(bus.ir_pc), 1);
      check("stall_addr",  32'(bus.instruction_address), 2);
      check("stall_valid", 32'(bus.ir_valid), 1);
    end
    bus.ir_ready = 1'b1;
    tick();
    check("release_data", 32'(bus.ir_data), 32'h A3);
    check("release_pc",   32'(bus.ir_pc), 2);
    bus.enable = 1'b0;
    tick();
    tick();

    // Branch flush while IR valid, then redirect while IDLE.
    do_reset();
    bus.enable   = 1'b1;
    bus.ir_ready = 1'b1;
    tick();
    tick();
    bus.ir_ready      = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    tick();
    check("branch_flush", 32'(bus.ir_valid), 0);
    check("branch_addr",  32'(bus.instruction_address), 32'h40);
    bus.branch_taken = 1'b0;
    bus.ir_ready     = 1'b1;
    push(8'hB0, 8'h40);
    tick();
    check("branch_valid", 32'(bus.ir_valid), 1);
    check("branch_pc",    32'(bus.ir_pc), 32'h40);
    check("branch_data",  32'(bus.ir_data), 32'h B0);
    bus.enable = 1'b0;
    tick();
    check("idle_drained", 32'(bus.ir_valid), 0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'hFE;
    tick();
    bus.branch_taken = 1'b0;
    check("idle_branch_addr", 32'(bus.instruction_address), 32'hFE);

    // PC wrap 0xFE -> 0xFF -> 0x00 with no gap.
    push(8'hC0, 8'hFE);
    push(8'hC1, 8'hFF);
    push(8'hA1, 8'h00);
    bus.enable = 1'b1;
    tick();
    tick();
    check("wrap_pc_fe", 32'(bus.ir_pc), 32'hFE);
    tick();
    check("wrap_pc_ff", 32'(bus.ir_pc), 32'hFF);
    tick();
    check("wrap_pc_00",   32'(bus.ir_pc), 32'h00);
    check("wrap_data_00", 32'(bus.ir_data), 32'h A1);
    check("wrap_valid",   32'(bus.ir_valid), 1);
    bus.enable = 1'b0;
    tick();
    tick();

    // Halt at address 5.
    mem[4] = 8'hA5;
    mem[5] = 8'hFF;
    do_reset();
    push(8'hA1, 8'h00);
    push(8'hA2, 8'h01);
    push(8'hA3, 8'h02);
    push(8'hA4, 8'h03);
    push(8'hA5, 8'h04);
    push(8'hFF, 8'h05);
    bus.enable   = 1'b1;
    bus.ir_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    tick();
    bus.ir_ready      = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    check("halt_ir_data",  32'(bus.ir_data), 32'hFF);
    check("halt_ir_pc",    32'(bus.ir_pc), 5);
    check("halt_ir_valid", 32'(bus.ir_valid), 1);
    check("halt_addr",     32'(bus.instruction_address), 5);
    check("halt_not_yet",  32'(bus.halted), 0);
    tick();
    check("halt_branch_ignored", 32'(bus.instruction_address), 5);
    check("halt_ir_kept",        32'(bus.ir_valid), 1);
    check("halt_still_not_yet",  32'(bus.halted), 0);
    bus.branch_taken = 1'b0;
    bus.ir_ready     = 1'b1;
    tick();
    check("halted_set",    32'(bus.halted), 1);
    check("halted_ir_gone", 32'(bus.ir_valid), 0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    tick();
    bus.branch_taken = 1'b0;
    check("halted_addr_frozen", 32'(bus.instruction_address), 5);
    check("halted_sticky",      32'(bus.halted), 1);
`ifdef INSTRUCTION_FETCH_COUNT_EN
    check("halt_count", 32'(bus.fetch_count), 6);
`endif
    #3;
    reset = 1'b1;
    #1;
    check("halt_cleared_by_reset", 32'(bus.halted), 0);
    check("halt_reset_addr",       32'(bus.instruction_address), 0);

    // Asynchronous reset between edges while streaming.
    do_reset();
    push(8'hA1, 8'h00);
    bus.enable   = 1'b1;
    bus.ir_ready = 1'b1;
    tick();
    tick();
    tick();
    check("pre_async_valid", 32'(bus.ir_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_ir_valid", 32'(bus.ir_valid), 0);
    check("async_ir_data",  32'(bus.ir_data), 0);
    check("async_ir_pc",    32'(bus.ir_pc), 0);
    check("async_addr",     32'(bus.instruction_address), 0);
    check("async_halted",   32'(bus.halted), 0);
`ifdef INSTRUCTION_FETCH_COUNT_EN
    check("async_count",    32'(bus.fetch_count), 0);
`endif
    do_reset();
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instruction_mem.
- Holds the program counter and drives instruction_address combinationally from it. instruction_mem returns instruction_data in the same cycle (asynchronous read).
- Registers the fetched byte into a one-entry instruction register (IR) with a valid/ready handshake to decode.
- Handles branch redirect, IR flush, halt detection and PC wrap-around.

Parameters:
- ADDR_WIDTH, 8, width of PC and instruction_address.
- DATA_WIDTH, 8, width of instruction_data and IR.
- RESET_PC, 8'h00, PC value after reset.
- HALT_OPCODE, 8'hFF, instruction that stops fetching.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  fetch permitted while high.
- instruction_address  output  ADDR_WIDTH  to instruction_mem; equals PC.
- instruction_data  input  DATA_WIDTH  from instruction_mem, same-cycle.
- ir_data  output  DATA_WIDTH  registered instruction to decode.
- ir_pc  output  ADDR_WIDTH  address ir_data was fetched from.
- ir_valid  output  1  IR holds an instruction.
- ir_ready  input  1  decode accepts IR this cycle.
- branch_taken  input  1  redirect request, single-cycle pulse.
- branch_target  input  ADDR_WIDTH  redirect address.
- halted  output  1  halt opcode fetched and consumed.

Behaviour:
- Interface fixed: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (async, any state, mid-fetch included): PC=RESET_PC, ir_data=0, ir_pc=0, ir_valid=0, halted=0, state=IDLE.
- States:
  - IDLE: PC frozen. enable=1 -> RUN next edge.
  - RUN: fetch active. enable=0 -> IDLE, with no capture that cycle.
  - HALT: no fetch, PC frozen. Left only by reset.
- instruction_address = PC at all times, combinational.
- Capture condition: state=RUN, enable=1, branch_taken=0, and (ir_valid=0 or ir_ready=1).
- On capture, at the next edge:
  - ir_data <= instruction_data, ir_pc <= PC, ir_valid <= 1.
  - PC <= PC+1, modulo 2^ADDR_WIDTH (8'hFF wraps to 8'h00, no flag).
- Zero-bubble throughput: with ir_ready held high, one instruction per cycle; first ir_valid one cycle after entering RUN.
- Stall: ir_valid=1 and ir_ready=0 -> IR, ir_pc and PC all hold.
- Consume without capture: ir_ready=1 with no capture -> ir_valid <= 0.
- Branch (highest priority after reset; any state except HALT):
  - PC <= branch_target, ir_valid <= 0 (IR flushed; ir_data/ir_pc keep stale values).
  - No capture that cycle.
  - In IDLE, PC is still redirected.
- Halt:
  - When captured instruction_data == HALT_OPCODE: state -> HALT and PC stays at the halt address (not incremented).
  - The IR presents the halt instruction normally.
  - halted <= 1 on the edge where decode accepts it (ir_valid & ir_ready in HALT); ir_valid then drops to 0.
  - branch_taken is ignored in HALT.
- Simultaneous ir_ready=1 and capture: old IR consumed, new IR loaded; ir_valid stays 1.

Optional Feature:
- Macro: INSTRUCTION_FETCH_COUNT_EN.
- Defined: adds output fetch_count [15:0].
  - Reset 0; +1 on every capture; saturates at 16'hFFFF.
  - Not incremented on flushed or stalled cycles.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package: fetch state enum (IDLE/RUN/HALT), ADDR_WIDTH/DATA_WIDTH defaults, HALT_OPCODE constant, RESET_PC.
- One natural sub-module: fetch_pc_reg. Holds the PC register with increment, hold, redirect and wrap; keeps the next-PC priority (reset > branch > capture > hold) in one place.
- The IR and state machine stay in the top.

Test Plan:
- Reset, enable=1, memory 0x00..0x03 = A1,A2,A3,A4, ir_ready=1 -> ir_pc 0,1,2,3 on consecutive cycles, ir_data A1..A4, ir_valid continuous.
- Hold ir_ready=0 for 3 cycles at PC=2 -> ir_data/ir_pc frozen at (A2,1), instruction_address stays 2. Release -> A3 next cycle, nothing lost or duplicated.
- branch_taken=1, branch_target=0x40 while ir_valid=1 -> next cycle ir_valid=0 and instruction_address=0x40; the cycle after, ir_pc=0x40.
- PC run to 0xFE with non-halt data -> ir_pc 0xFE, 0xFF, 0x00, with no gap.
- mem[0x05]=0xFF -> IR shows 0xFF @ ir_pc 5 and instruction_address stays 5. halted rises the edge after ir_ready=1 accepts it. Later branch_taken has no effect; only reset clears halted.
- Assert reset asynchronously mid-RUN between edges -> outputs drop to reset values immediately, PC=RESET_PC. With INSTRUCTION_FETCH_COUNT_EN defined, fetch_count=0 after reset and equals 4 after the first scenario.
